// File: rtl/iob_bus_arbiter.sv
// iob_bus_arbiter: shares one native IOb slave port between two masters, one transaction at a time.
// Build option: define IOB_ARB_ROUND_ROBIN_EN for round-robin priority (default: m0 always wins ties).
module iob_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0] m0_req,
    output logic [DATA_W:0]                 m0_resp,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0] m1_req,
    output logic [DATA_W:0]                 m1_resp,
    output logic [ADDR_W+DATA_W+DATA_W/8:0] s_req,
    input  logic [DATA_W:0]                 s_resp,
    output logic [1:0]                      grant
);
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int PAY_W  = REQ_W - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r;
    logic [1:0]       grant_r;
    logic [PAY_W-1:0] payload_r;

    logic             m0_valid_s;
    logic             m1_valid_s;
    logic             s_ready_s;
    logic             pick_m1_s;
    logic [PAY_W-1:0] win_payload_s;

`ifdef IOB_ARB_ROUND_ROBIN_EN
    // 1 when m1 held the port most recently; reset value makes m0 preferred.
    logic             last_m1_r;
`endif

    assign m0_valid_s    = m0_req[REQ_W-1];
    assign m1_valid_s    = m1_req[REQ_W-1];
    assign s_ready_s     = s_resp[0];
    assign win_payload_s = pick_m1_s ? m1_req[PAY_W-1:0] : m0_req[PAY_W-1:0];

    // Winner selection among the masters requesting in the current cycle
    always_comb begin
        pick_m1_s = 1'b0;
        if (m0_valid_s && m1_valid_s) begin
`ifdef IOB_ARB_ROUND_ROBIN_EN
            pick_m1_s = ~last_m1_r;
`else
            pick_m1_s = 1'b0;
`endif
        end else if (m1_valid_s) begin
            pick_m1_s = 1'b1;
        end else begin
            pick_m1_s = 1'b0;
        end
    end

    // Ownership FSM: capture the winner's request in IDLE, hold it until the slave answers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            grant_r   <= 2'b00;
            payload_r <= {PAY_W{1'b0}};
`ifdef IOB_ARB_ROUND_ROBIN_EN
            last_m1_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (m0_valid_s || m1_valid_s) begin
                        state_r   <= BUSY;
                        grant_r   <= pick_m1_s ? 2'b10 : 2'b01;
                        payload_r <= win_payload_s;
`ifdef IOB_ARB_ROUND_ROBIN_EN
                        last_m1_r <= pick_m1_s;
`endif
                    end
                end
                BUSY: begin
                    // Payload is cleared on completion so s_req reads all-zero in IDLE.
                    if (s_ready_s) begin
                        state_r   <= IDLE;
                        grant_r   <= 2'b00;
                        payload_r <= {PAY_W{1'b0}};
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    grant_r   <= 2'b00;
                    payload_r <= {PAY_W{1'b0}};
                end
            endcase
        end
    end

    // Response steering: only the granted master sees the slave response
    always_comb begin
        m0_resp = {(DATA_W+1){1'b0}};
        m1_resp = {(DATA_W+1){1'b0}};
        if (grant_r[0]) begin
            m0_resp = s_resp;
        end else if (grant_r[1]) begin
            m1_resp = s_resp;
        end else begin
            m0_resp = {(DATA_W+1){1'b0}};
            m1_resp = {(DATA_W+1){1'b0}};
        end
    end

    assign s_req = {(state_r == BUSY), payload_r};
    assign grant = grant_r;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Scoreboard bench for iob_bus_arbiter: drivers push issued requests, a negedge monitor checks
// every cycle against a transaction-level ownership/priority model.
`timescale 1ns/1ps
module tb_iob_bus_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int REQ_W  = 1 + AW + DW + SW;
    localparam int PAY_W  = REQ_W - 1;
    localparam int RESP_W = DW + 1;
`ifdef IOB_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [REQ_W-1:0]  m0_req_v = '0;
    logic [REQ_W-1:0]  m1_req_v = '0;
    logic [RESP_W-1:0] m0_resp_w;
    logic [RESP_W-1:0] m1_resp_w;
    logic [REQ_W-1:0]  s_req_w;
    logic [RESP_W-1:0] s_resp_v = '0;
    logic [1:0]        grant_w;

    int errors = 0;
    int checks = 0;

    // Requests issued by each master and not yet completed, oldest first.
    logic [PAY_W-1:0] q0[$];
    logic [PAY_W-1:0] q1[$];
    int m_owner = -1;
    int m_last  = 1;
    logic [PAY_W-1:0] mon_head;

    bit          sl_fixed    = 1'b0;
    int          sl_lat      = 0;
    logic [DW-1:0] sl_fix_rd = '0;
    bit          sl_spurious = 1'b0;
    bit          sl_active   = 1'b0;
    int          sl_cnt      = 0;
    logic [DW-1:0] sl_rd     = '0;

    always #5 clk = ~clk;

    iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req_v),
        .m0_resp (m0_resp_w),
        .m1_req  (m1_req_v),
        .m1_resp (m1_resp_w),
        .s_req   (s_req_w),
        .s_resp  (s_resp_v),
        .grant   (grant_w)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [PAY_W-1:0] pay(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                             input logic [SW-1:0] s);
        return {a, d, s};
    endfunction

    // Tie rule: fixed m0 priority, or the master not granted most recently.
    function automatic int predict_winner(input bit v0, input bit v1, input int last);
        if (v0 && v1) return (RR_EN && last == 0) ? 1 : 0;
        return (v1 && !v0) ? 1 : 0;
    endfunction

    task automatic model_arbitrate();
        if (m0_req_v[REQ_W-1] || m1_req_v[REQ_W-1]) begin
            m_owner = predict_winner(m0_req_v[REQ_W-1], m1_req_v[REQ_W-1], m_last);
            m_last  = m_owner;
        end
    endtask

    task automatic set_req(input int id, input logic [REQ_W-1:0] v);
        if (id == 0) m0_req_v = v;
        else         m1_req_v = v;
    endtask

    task automatic issue(input int id, input logic [PAY_W-1:0] p);
        set_req(id, {1'b1, p});
        if (id == 0) q0.push_back(p);
        else         q1.push_back(p);
    endtask

    task automatic wait_ready(input int id, input int max_cyc, output int n);
        n = 0;
        while (!(id == 0 ? m0_resp_w[0] : m1_resp_w[0]) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) fail("wait_ready");
    endtask

    // Called at a negedge: retire each master's request on its ready until none is pending.
    task automatic drain(input int max_cyc);
        int n;
        bit d0;
        bit d1;
        n = 0;
        while ((m0_req_v[REQ_W-1] || m1_req_v[REQ_W-1]) && n < max_cyc) begin
            d0 = m0_resp_w[0];
            d1 = m1_resp_w[0];
            @(posedge clk); #1;
            if (d0) set_req(0, '0);
            if (d1) set_req(1, '0);
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) fail("drain");
    endtask

    // Random master: issues n requests, optionally disturbing its inputs while granted.
    task automatic drive(input int id, input int n, input int max_gap, input bit mut);
        int  gap;
        int  waited;
        bit  done;
        bit  do_mut;
        for (int t = 0; t < n; t++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            issue(id, pay($urandom, $urandom, 4'($urandom_range(0, 15))));
            waited = 0;
            done   = 1'b0;
            while (!done && waited < 300) begin
                @(negedge clk);
                if (id == 0 ? m0_resp_w[0] : m1_resp_w[0]) begin
                    done = 1'b1;
                end else begin
                    do_mut = mut && (id == 0 ? grant_w[0] : grant_w[1]) && ($urandom_range(0, 3) == 0);
                    @(posedge clk); #1;
                    if (do_mut) begin
                        if ($urandom_range(0, 1) == 0) set_req(id, '0);
                        else set_req(id, {1'b1, pay($urandom, $urandom, 4'($urandom_range(0, 15)))});
                    end
                    waited++;
                end
            end
            if (!done) fail("driver");
            @(posedge clk); #1;
            set_req(id, '0);
        end
    endtask

    // Slave model: answers after a fixed or random number of busy cycles
    initial begin
        forever begin
            @(posedge clk); #1;
            s_resp_v = '0;
            if (rst || !s_req_w[REQ_W-1]) begin
                sl_active = 1'b0;
                if (sl_spurious) s_resp_v = {32'hBADC0FFE, 1'b1};
            end else begin
                if (!sl_active) begin
                    sl_active = 1'b1;
                    sl_cnt    = sl_fixed ? sl_lat : $urandom_range(0, 3);
                    sl_rd     = sl_fixed ? sl_fix_rd : $urandom;
                end
                if (sl_cnt == 0) begin
                    s_resp_v  = {sl_rd, 1'b1};
                    sl_active = 1'b0;
                end else begin
                    sl_cnt--;
                end
            end
        end
    end

    // Monitor: compares every cycle against the ownership model and pops completed requests
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_grant", grant_w, 2'b00);
            chk("rst_sreq", s_req_w, '0);
            chk("rst_ready", {m1_resp_w[0], m0_resp_w[0]}, 2'b00);
            m_last  = 1;
            m_owner = -1;
            model_arbitrate();
        end else if (m_owner < 0) begin
            chk("idle_grant", grant_w, 2'b00);
            chk("idle_sreq", s_req_w, '0);
            chk("idle_m0_resp", m0_resp_w, '0);
            chk("idle_m1_resp", m1_resp_w, '0);
            model_arbitrate();
        end else if ((m_owner == 0 ? q0.size() : q1.size()) == 0) begin
            fail("sb_underflow");
            m_owner = -1;
        end else begin
            mon_head = (m_owner == 0) ? q0[0] : q1[0];
            chk("busy_grant", grant_w, (m_owner == 0) ? 2'b01 : 2'b10);
            chk("busy_sreq", s_req_w, {1'b1, mon_head});
            chk("owner_resp", (m_owner == 0) ? m0_resp_w : m1_resp_w, s_resp_v);
            chk("other_resp", (m_owner == 0) ? m1_resp_w : m0_resp_w, '0);
            if (s_resp_v[0]) begin
                if (m_owner == 0) void'(q0.pop_front());
                else              void'(q1.pop_front());
                m_owner = -1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Contention right after reset, then the winner re-requests while the loser waits.
        sl_fixed  = 1'b1;
        sl_lat    = 1;
        sl_fix_rd = 32'h0000_1111;
        issue(0, pay(32'h10, 32'hA0A0A0A0, 4'hF));
        issue(1, pay(32'h20, 32'h0, 4'h0));
        @(negedge clk);
        @(negedge clk); chk("pair1_first", grant_w, 2'b01);
        wait_ready(0, 20, n);
        @(posedge clk); #1;
        issue(0, pay(32'h14, 32'hB1B1B1B1, 4'h3));
        @(negedge clk); chk("bubble_grant", grant_w, 2'b00);
        @(negedge clk); chk("pair2_first", grant_w, RR_EN ? 2'b10 : 2'b01);
        drain(40);

        // Single read from m1.
        @(posedge clk); #1;
        sl_lat    = 3;
        sl_fix_rd = 32'hDEADBEEF;
        issue(1, pay(32'h100, 32'h0, 4'h0));
        @(negedge clk);
        @(negedge clk); chk("rd_grant", grant_w, 2'b10);
        wait_ready(1, 20, n);
        chk("rd_latency", n, 3);
        chk("rd_m1_resp", m1_resp_w, {32'hDEADBEEF, 1'b1});
        chk("rd_m0_resp", m0_resp_w, '0);
        @(posedge clk); #1;
        set_req(1, '0);

        // Held write: master changes its address while the transaction is in flight.
        issue(0, pay(32'h40, 32'h12345678, 4'hF));
        @(negedge clk);
        @(negedge clk); chk("hold_grant", grant_w, 2'b01);
        @(posedge clk); #1;
        set_req(0, {1'b1, pay(32'h80, 32'h12345678, 4'hF)});
        @(negedge clk); chk("hold_sreq", s_req_w, {1'b1, pay(32'h40, 32'h12345678, 4'hF)});
        drain(20);

        // Spurious slave ready while idle.
        sl_spurious = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spur_ready", {m1_resp_w[0], m0_resp_w[0]}, 2'b00);
            chk("spur_grant", grant_w, 2'b00);
        end
        sl_spurious = 1'b0;

        // Random traffic from both masters with random slave latency.
        sl_fixed = 1'b0;
        @(posedge clk); #1;
        fork
            drive(0, 25, 3, 1'b1);
            drive(1, 25, 3, 1'b1);
        join

        // m0 back-to-back, m1 once.
        fork
            drive(0, 5, 0, 1'b0);
            begin
                @(posedge clk); #1;
                drive(1, 1, 0, 1'b0);
            end
        join

        // Reset while busy; the still-pending m1 request is re-granted after release.
        @(posedge clk); #1;
        sl_fixed  = 1'b1;
        sl_lat    = 5;
        sl_fix_rd = 32'h0BAD_F00D;
        issue(1, pay(32'h200, 32'h55AA55AA, 4'h1));
        @(negedge clk);
        @(negedge clk); chk("pre_rst_grant", grant_w, 2'b10);
        @(posedge clk); #2;
        rst = 1'b1;
        sl_active = 1'b0;
        #1;
        chk("rst_async_grant", grant_w, 2'b00);
        chk("rst_async_valid", s_req_w[REQ_W-1], 1'b0);
        chk("rst_async_ready", m1_resp_w[0], 1'b0);
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk); chk("post_rst_grant", grant_w, 2'b10);
        drain(20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
